vector_mem_responder: RTL and testbench

//  Memory-side responder for the memory-to-memory vector datapath. It serves the read and write

---
 rtl/vmem_pkg.sv | 17 +
 rtl/vmem_ram.sv | 38 +++
 rtl/vector_mem_responder.sv | 125 ++++++++++++
 tb/tb_vector_mem_responder.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vmem_pkg.sv
// Shared encodings and default geometry for the vector memory responder and its control unit.
// Pure declarations: no latency, no flow control.
package vmem_pkg;

    localparam int VM_DATA_W  = 16;
    localparam int VM_ADDR_W  = 10;
    localparam int VM_LEN_W   = 4;
    localparam int VM_MAX_LEN = 8;

    typedef enum logic [1:0] {
        VM_IDLE     = 2'd0,
        VM_WRITE    = 2'd1,
        VM_RD_ISSUE = 2'd2,
        VM_RD_HOLD  = 2'd3
    } vm_state_e;

endpackage

// File: rtl/vmem_ram.sv
// Single-port synchronous RAM, one-cycle read latency, registered read data cleared by reset.
// No flow control: the caller never asserts write and read enables together.
module vmem_ram
    import vmem_pkg::*;
#(
    parameter int DATA_W = VM_DATA_W,
    parameter int ADDR_W = VM_ADDR_W
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              we_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [2**ADDR_W];
    logic [DATA_W-1:0] rdata_q;

    // Storage array is deliberately left out of reset so contents survive it.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/vector_mem_responder.sv
// Burst read/write responder over an internal RAM; first read beat two cycles after acceptance.
// Write beats accepted 1/cycle; read beats 1 per 2 cycles, rd_valid/rd_data held while rd_ready is low.
module vector_mem_responder
    import vmem_pkg::*;
#(
    parameter int DATA_W  = VM_DATA_W,
    parameter int ADDR_W  = VM_ADDR_W,
    parameter int LEN_W   = VM_LEN_W,
    parameter int MAX_LEN = VM_MAX_LEN
) (
    input  logic              clock_i,
    input  logic              reset_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_write_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [LEN_W-1:0]  req_len_i,
    input  logic              wr_valid_i,
    output logic              wr_ready_o,
    input  logic [DATA_W-1:0] wr_data_i,
    output logic              rd_valid_o,
    input  logic              rd_ready_i,
    output logic [DATA_W-1:0] rd_data_o,
    output logic              rd_last_o,
    output logic              done_o,
    output logic              busy_o,
    output logic [1:0]        current_state_o
);

    vm_state_e         state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [LEN_W-1:0]  cnt_q;
    logic              done_q;

    logic [LEN_W-1:0]  len_eff;
    logic              last_beat;
    logic              wr_fire;
    logic              rd_fire;
    logic              ram_we;
    logic              ram_re;

    assign len_eff   = (req_len_i > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : req_len_i;
    assign last_beat = (cnt_q == LEN_W'(1));
    assign wr_fire   = (state_q == VM_WRITE) && wr_valid_i;
    assign rd_fire   = (state_q == VM_RD_HOLD) && rd_ready_i;
    // A beat presented on a reset edge must not reach the array.
    assign ram_we    = wr_fire && reset_i;
    assign ram_re    = (state_q == VM_RD_ISSUE);

    vmem_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk_i   (clock_i),
        .rst_n_i (reset_i),
        .we_i    (ram_we),
        .re_i    (ram_re),
        .addr_i  (addr_q),
        .wdata_i (wr_data_i),
        .rdata_o (rd_data_o)
    );

    always_ff @(posedge clock_i) begin
        if (!reset_i) begin
            state_q <= VM_IDLE;
            addr_q  <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                VM_IDLE: begin
                    if (req_valid_i) begin
                        addr_q <= req_addr_i;
                        cnt_q  <= len_eff;
                        if (len_eff == '0) begin
                            done_q <= 1'b1;
                        end else if (req_write_i) begin
                            state_q <= VM_WRITE;
                        end else begin
                            state_q <= VM_RD_ISSUE;
                        end
                    end
                end
                VM_WRITE: begin
                    if (wr_fire) begin
                        addr_q <= addr_q + ADDR_W'(1);
                        cnt_q  <= cnt_q - LEN_W'(1);
                        if (last_beat) begin
                            state_q <= VM_IDLE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                VM_RD_ISSUE: begin
                    state_q <= VM_RD_HOLD;
                end
                VM_RD_HOLD: begin
                    if (rd_fire) begin
                        addr_q <= addr_q + ADDR_W'(1);
                        cnt_q  <= cnt_q - LEN_W'(1);
                        if (last_beat) begin
                            state_q <= VM_IDLE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= VM_RD_ISSUE;
                        end
                    end
                end
                default: begin
                    state_q <= VM_IDLE;
                end
            endcase
        end
    end

    assign req_ready_o     = (state_q == VM_IDLE);
    assign wr_ready_o      = (state_q == VM_WRITE);
    assign rd_valid_o      = (state_q == VM_RD_HOLD);
    assign rd_last_o       = rd_valid_o && last_beat;
    assign done_o          = done_q;
    assign busy_o          = (state_q != VM_IDLE);
    assign current_state_o = state_q;

endmodule

// File: tb/tb_vector_mem_responder.sv
// Directed bench for vector_mem_responder with a transaction-level memory model and per-cycle compare.
module tb_vector_mem_responder;

    localparam int DW = 16;
    localparam int AW = 10;
    localparam int LW = 4;
    localparam int ML = 8;

    logic          clk = 1'b0;
    logic          reset_i, req_valid_i, req_write_i, wr_valid_i, rd_ready_i;
    logic [AW-1:0] req_addr_i;
    logic [LW-1:0] req_len_i;
    logic [DW-1:0] wr_data_i;
    logic          req_ready_o, wr_ready_o, rd_valid_o, rd_last_o, done_o, busy_o;
    logic [DW-1:0] rd_data_o;
    logic [1:0]    current_state_o;

    always #5 clk = ~clk;

    vector_mem_responder dut (
        .clock_i         (clk),
        .reset_i         (reset_i),
        .req_valid_i     (req_valid_i),
        .req_ready_o     (req_ready_o),
        .req_write_i     (req_write_i),
        .req_addr_i      (req_addr_i),
        .req_len_i       (req_len_i),
        .wr_valid_i      (wr_valid_i),
        .wr_ready_o      (wr_ready_o),
        .wr_data_i       (wr_data_i),
        .rd_valid_o      (rd_valid_o),
        .rd_ready_i      (rd_ready_i),
        .rd_data_o       (rd_data_o),
        .rd_last_o       (rd_last_o),
        .done_o          (done_o),
        .busy_o          (busy_o),
        .current_state_o (current_state_o)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Transaction-level model: memory image, pending read beats, burst bookkeeping.
    typedef struct {
        logic [DW-1:0] d;
        bit            last;
        bit            known;
    } beat_t;

    logic [DW-1:0] mm [1<<AW];
    bit            mk [1<<AW];
    beat_t         exp_q[$];
    logic [DW-1:0] cap_q[$];
    logic [DW-1:0] wdat[$];
    logic [DW-1:0] refv[$];
    bit            mon_en = 0, m_busy = 0, m_write = 0, m_done = 0, m_first = 0, m_hold = 0, acc_done = 0;
    logic [AW-1:0] m_addr = '0;
    int            m_left = 0, acc_cyc = 0, done_cnt = 0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (mon_en) begin
            bit            nd;
            int            len;
            logic [AW-1:0] a;
            beat_t         b;
            chk("busy", busy_o, m_busy);
            chk("req_ready", req_ready_o, !m_busy);
            chk("wr_ready", wr_ready_o, m_busy && m_write);
            chk("done", done_o, m_done);
            if (done_o) done_cnt++;
            if (m_hold) chk("rd_valid_held", rd_valid_o, 1);
            if (rd_valid_o) begin
                if (exp_q.size() == 0 || !m_busy || m_write) begin
                    chk("rd_valid_spurious", rd_valid_o, 0);
                end else begin
                    if (exp_q[0].known) chk("rd_data", rd_data_o, exp_q[0].d);
                    chk("rd_last", rd_last_o, exp_q[0].last);
                    if (m_first) begin
                        chk("rd_first_latency", cyc - acc_cyc, 1);
                        m_first = 0;
                    end
                end
            end
            m_hold = rd_valid_o && !rd_ready_i && reset_i;
            nd = 0;
            if (!reset_i) begin
                m_busy  = 0;
                m_first = 0;
                m_hold  = 0;
                exp_q.delete();
            end else if (!m_busy && req_valid_i) begin
                len      = (req_len_i > ML) ? ML : int'(req_len_i);
                acc_cyc  = cyc + 1;
                acc_done = done_o;
                if (len == 0) begin
                    nd = 1;
                end else begin
                    m_busy  = 1;
                    m_write = req_write_i;
                    m_addr  = req_addr_i;
                    m_left  = len;
                    if (!req_write_i) begin
                        m_first = 1;
                        for (int i = 0; i < len; i++) begin
                            a       = req_addr_i + AW'(i);
                            b.d     = mm[a];
                            b.known = mk[a];
                            b.last  = (i == len - 1);
                            exp_q.push_back(b);
                        end
                    end
                end
            end else if (m_busy && m_write && wr_valid_i) begin
                mm[m_addr] = wr_data_i;
                mk[m_addr] = 1;
                m_addr++;
                m_left--;
                if (m_left == 0) begin
                    m_busy = 0;
                    nd     = 1;
                end
            end else if (m_busy && !m_write && rd_valid_o && rd_ready_i && exp_q.size() > 0) begin
                cap_q.push_back(rd_data_o);
                void'(exp_q.pop_front());
                m_left--;
                if (m_left == 0) begin
                    m_busy = 0;
                    nd     = 1;
                end
            end
            m_done = nd;
        end
    end

    task automatic send_req(input bit w, input logic [AW-1:0] a, input logic [LW-1:0] l, output int waited);
        bit ok;
        ok = 0;
        waited = 0;
        @(posedge clk); #1;
        req_valid_i = 1; req_write_i = w; req_addr_i = a; req_len_i = l;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (req_ready_o) begin ok = 1; break; end
            waited++;
        end
        if (!ok) chk("req_accept_timeout", ok, 1);
        @(posedge clk); #1;
        req_valid_i = 0;
    endtask

    task automatic send_beats(input int n);
        bit ok;
        for (int i = 0; i < n; i++) begin
            ok = 0;
            wr_valid_i = 1;
            wr_data_i  = wdat[i];
            for (int t = 0; t < 50; t++) begin
                @(negedge clk);
                if (wr_ready_o) begin ok = 1; break; end
            end
            if (!ok) begin chk("wr_accept_timeout", ok, 1); break; end
            @(posedge clk); #1;
        end
        wr_valid_i = 0;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #2;
            if (!m_busy) begin ok = 1; break; end
        end
        if (!ok) chk("idle_timeout", ok, 1);
        @(negedge clk); #1;
    endtask

    task automatic wr_burst(input logic [AW-1:0] a, input logic [LW-1:0] l, input int n);
        int w;
        send_req(1, a, l, w);
        send_beats(n);
        wait_idle();
    endtask

    task automatic rd_burst(input logic [AW-1:0] a, input logic [LW-1:0] l);
        int w;
        cap_q.delete();
        send_req(0, a, l, w);
        wait_idle();
    endtask

    task automatic chk_cap(input string nm);
        chk({nm, "_beats"}, cap_q.size(), refv.size());
        for (int i = 0; i < refv.size() && i < cap_q.size(); i++)
            chk($sformatf("%s_beat%0d", nm, i), cap_q[i], refv[i]);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, w1, w2;
        reset_i = 0; req_valid_i = 0; req_write_i = 0; req_addr_i = '0; req_len_i = '0;
        wr_valid_i = 0; wr_data_i = '0; rd_ready_i = 1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_rd_valid", rd_valid_o, 0);
        chk("rst_rd_data", rd_data_o, 0);
        chk("rst_state", current_state_o, 0);
        reset_i = 1;
        mon_en  = 1;

        // Write then read back, no gaps.
        d0 = done_cnt;
        wdat = {16'h00A1, 16'h00A2, 16'h00A3, 16'h00A4};
        wr_burst(10'h010, 4, 4);
        rd_burst(10'h010, 4);
        refv = {16'h00A1, 16'h00A2, 16'h00A3, 16'h00A4};
        chk_cap("t2");
        chk("t2_done_pulses", done_cnt - d0, 2);

        // Consumer stalls for 5 cycles on the second beat.
        rd_ready_i = 0;
        cap_q.delete();
        send_req(0, 10'h010, 3, w1);
        for (int k = 0; k < 2; k++) begin
            for (int t = 0; t < 20 && !rd_valid_o; t++) begin @(posedge clk); #2; end
            chk("t3_valid_seen", rd_valid_o, 1);
            if (k == 1) begin
                repeat (5) begin @(posedge clk); #2; chk("t3_stall_valid", rd_valid_o, 1); end
                chk("t3_stall_data", rd_data_o, 16'h00A2);
            end
            rd_ready_i = 1;
            @(posedge clk); #1;
            rd_ready_i = 0;
        end
        rd_ready_i = 1;
        wait_idle();
        refv = {16'h00A1, 16'h00A2, 16'h00A3};
        chk_cap("t3");

        // Wrap past the top address.
        wdat = {16'h0001, 16'h0002, 16'h0003, 16'h0004};
        wr_burst(10'h3FE, 4, 4);
        rd_burst(10'h3FE, 4);
        refv = {16'h0001, 16'h0002, 16'h0003, 16'h0004};
        chk_cap("t4");
        rd_burst(10'h000, 2);
        refv = {16'h0003, 16'h0004};
        chk_cap("t4_wrap");

        // Zero length with stray write data; then an over-long burst clamped to 8.
        d0 = done_cnt;
        wr_valid_i = 1; wr_data_i = 16'hDEAD;
        send_req(1, 10'h3FE, 0, w1);
        @(negedge clk); #1;
        @(posedge clk); #1;
        wr_valid_i = 0;
        chk("t5_len0_done", done_cnt - d0, 1);
        rd_burst(10'h3FE, 2);
        refv = {16'h0001, 16'h0002};
        chk_cap("t5_len0");
        wdat = {16'h0100, 16'h0101, 16'h0102, 16'h0103, 16'h0104, 16'h0105, 16'h0106, 16'h0107};
        wr_burst(10'h020, 15, 8);
        rd_burst(10'h020, 15);
        refv = wdat;
        chk_cap("t5_clamp");

        // Read request raised mid-write, accepted in the done cycle.
        wdat = {16'h6000, 16'h6001, 16'h6002, 16'h6003};
        cap_q.delete();
        w2 = 0;
        fork
            begin send_req(1, 10'h040, 4, w1); send_beats(4); end
            begin repeat (3) @(posedge clk); send_req(0, 10'h040, 4, w2); end
        join
        wait_idle();
        chk("t6_req_blocked", w2 > 0, 1);
        chk("t6_accept_in_done", acc_done, 1);
        refv = wdat;
        chk_cap("t6");

        // Reset during a read burst, then during a write burst.
        send_req(0, 10'h010, 4, w1);
        repeat (2) @(posedge clk);
        #1; reset_i = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("t1r_busy", busy_o, 0);
        chk("t1r_rd_valid", rd_valid_o, 0);
        chk("t1r_rd_data", rd_data_o, 0);
        chk("t1r_done", done_o, 0);
        reset_i = 1;
        wdat = {16'h00B1, 16'h00B2, 16'h00B3, 16'h00B4};
        send_req(1, 10'h010, 4, w1);
        send_beats(2);
        reset_i = 0; wr_valid_i = 1; wr_data_i = 16'hEEEE;
        repeat (2) @(posedge clk);
        #1;
        chk("t1w_busy", busy_o, 0);
        chk("t1w_done", done_o, 0);
        chk("t1w_state", current_state_o, 0);
        reset_i = 1; wr_valid_i = 0;
        rd_burst(10'h010, 4);
        refv = {16'h00B1, 16'h00B2, 16'h00A3, 16'h00A4};
        chk_cap("t1");

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
